i2c_arb: RTL and testbench
==========================

I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one I2C master; legal values 2..4.
REQ-002 Parameter TIMEOUT_CYC, default 20'd1_000_000: WAIT-state watchdog limit in clk cycles; used only when I2C_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; the same clock as the I2C master's dri_clk domain.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req  in  NUM_REQ  per-requester transaction request; the requester holds it high until its rsp_done.
REQ-006 req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write.
REQ-007 req_bit16  in  NUM_REQ  per-requester register-address width: 1 = 16-bit, 0 = 8-bit.
REQ-008 req_slv  in  NUM_REQ*8  per-requester 8-bit slave address, packed with requester 0 in the LSBs.
REQ-009 req_addr  in  NUM_REQ*16  per-requester register address, packed.
REQ-010 req_wdata  in  NUM_REQ*8  per-requester write data, packed.
REQ-011 gnt  out  NUM_REQ  one-hot grant; all zeros when idle.
REQ-012 rsp_done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-013 rsp_rdata  out  8  read data; valid when any rsp_done bit is high.
REQ-014 rsp_err  out  1  NACK or timeout flag; valid when any rsp_done bit is high.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 i2c_exec  out  1  one-cycle start pulse to the I2C master.
REQ-017 i2c_bit_ctrl, i2c_rh_wl  out  1 each  address-width and read/write selects to the I2C master.
REQ-018 i2c_slv  out  8, i2c_addr  out  16, i2c_wdata  out  8: transaction fields to the I2C master.
REQ-019 i2c_rdata  in  8, i2c_done  in  1, i2c_ack  in  1: master results; i2c_ack = 1 means NACK.

Function
REQ-020 The FSM SHALL have exactly four states, IDLE, EXEC, WAIT and RESP, with the transitions in REQ-021 to REQ-024.
REQ-021 IDLE: when any req bit is high, the winner SHALL be the first set bit at or after rr_ptr, searching upward with wrap-around; the block SHALL latch the winner's rw, bit16, slv, addr and wdata, set gnt[winner], and go to EXEC.
REQ-022 EXEC: i2c_exec SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT; the latency from req rising in IDLE to i2c_exec is 2 cycles.
REQ-023 WAIT: on i2c_done the block SHALL capture i2c_rdata into rsp_rdata and i2c_ack into rsp_err, then go to RESP; i2c_done seen in any other state SHALL be ignored.
REQ-024 RESP: for one cycle the block SHALL assert rsp_done[winner], clear gnt, set rr_ptr to (winner+1) mod NUM_REQ, and return to IDLE.
REQ-025 The i2c_* field outputs SHALL stay stable from EXEC until the FSM leaves WAIT.
REQ-026 Dropping req during EXEC or WAIT SHALL NOT abort the transaction; it completes and rsp_done is still pulsed.
REQ-027 A requester holding req through RESP SHALL be arbitrated again in the following IDLE cycle under the normal round-robin order.
REQ-028 req changing while the FSM is outside IDLE SHALL have no effect until the FSM returns to IDLE.
REQ-029 On a write, rsp_rdata SHALL hold whatever i2c_rdata was at i2c_done; requesters ignore it.

Reset
REQ-030 On rst the block SHALL enter IDLE with rr_ptr = 0, gnt = 0, rsp_done = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, i2c_exec = 0 and all i2c_* field outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL abort without any rsp_done pulse; after reset the I2C master is treated as idle.

Configuration
REQ-032 With macro I2C_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT, and if it reaches TIMEOUT_CYC before i2c_done, the FSM SHALL go to RESP with rsp_err = 1 and rsp_rdata = 8'h00.
REQ-033 With I2C_ARB_TIMEOUT_EN undefined, the block SHALL contain no counter logic, and WAIT SHALL wait for i2c_done indefinitely.

Structure
REQ-034 A shared package i2c_arb_pkg SHALL hold the FSM state encoding (IDLE = 2'd0, EXEC = 2'd1, WAIT = 2'd2, RESP = 2'd3) and the default TIMEOUT_CYC.
REQ-035 Winner selection SHALL be a single sub-module, rr_pick, that is purely combinational with inputs req and rr_ptr and outputs a one-hot winner and its index.

Verification
REQ-036 Single write: req[0] with slv 8'h98, addr 16'h00FF, wdata 8'h80 -> gnt = 2'b01 at cycle +1, i2c_exec at cycle +2, and after i2c_done with ack 0, rsp_done = 2'b01 with rsp_err = 0.
REQ-037 Contention: req = 2'b11 from reset, held continuously -> grants alternate 0, 1, 0, 1 over four transactions, with exactly one i2c_exec per transaction.
REQ-038 Read with NACK: req[1] read, master returns i2c_rdata 8'hA5 and i2c_ack 1 -> rsp_done = 2'b10, rsp_rdata = 8'hA5, rsp_err = 1.
REQ-039 Abort: rst asserted in WAIT -> all outputs return to zero within the reset, no rsp_done pulse, and the next req is served normally.
REQ-040 Timeout (macro defined, TIMEOUT_CYC = 100, i2c_done never arrives) -> rsp_done exactly 100 cycles after WAIT entry, with rsp_err = 1 and rsp_rdata = 8'h00.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the i2c_arb requester arbiter.
// Optional WAIT watchdog is enabled by defining I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  // Index width covers the full legal NUM_REQ range of 2..4.
  localparam int unsigned IdxW = 2;

  localparam logic [19:0] TimeoutCycDefault = 20'd1_000_000;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin winner search: first set req bit at or after rr_ptr, wrapping.
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IdxW-1:0]    win_idx,
  output logic               win_any
);

  int unsigned        idx;
  logic [NUM_REQ-1:0] sel;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      sel = NUM_REQ'(1) << idx;
      if (!win_any && (|(req & sel))) begin
        win_oh  = sel;
        win_idx = IdxW'(idx);
        win_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC cycles.
module i2c_arb
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter logic [19:0] TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [NUM_REQ-1:0]     req_bit16,
  input  logic [NUM_REQ*8-1:0]   req_slv,
  input  logic [NUM_REQ*16-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   i2c_exec,
  output logic                   i2c_bit_ctrl,
  output logic                   i2c_rh_wl,
  output logic [7:0]             i2c_slv,
  output logic [15:0]            i2c_addr,
  output logic [7:0]             i2c_wdata,
  input  logic [7:0]             i2c_rdata,
  input  logic                   i2c_done,
  input  logic                   i2c_ack
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC == 20'd0) begin : gen_cfg_err
    $error("i2c_arb: NUM_REQ must be 2..4 and TIMEOUT_CYC nonzero");
  end

  arb_state_e         state;
  logic [IdxW-1:0]    rr_ptr;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    ptr_next;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [19:0]        wait_cnt;
`endif

  // Fields padded to four requesters so the 2-bit winner index selects directly.
  logic [3:0]  rw_pad;
  logic [3:0]  b16_pad;
  logic [31:0] slv_pad;
  logic [31:0] wdata_pad;
  logic [63:0] addr_pad;

  assign rw_pad    = 4'(req_rw);
  assign b16_pad   = 4'(req_bit16);
  assign slv_pad   = 32'(req_slv);
  assign wdata_pad = 32'(req_wdata);
  assign addr_pad  = 64'(req_addr);

  assign ptr_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win_oh (pick_oh),
    .win_idx(pick_idx),
    .win_any(pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      rr_ptr       <= '0;
      win_idx      <= '0;
      gnt          <= '0;
      rsp_done     <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      i2c_exec     <= 1'b0;
      i2c_bit_ctrl <= 1'b0;
      i2c_rh_wl    <= 1'b0;
      i2c_slv      <= '0;
      i2c_addr     <= '0;
      i2c_wdata    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (pick_any) begin
            state        <= StExec;
            busy         <= 1'b1;
            gnt          <= pick_oh;
            win_idx      <= pick_idx;
            i2c_bit_ctrl <= b16_pad[pick_idx];
            i2c_rh_wl    <= rw_pad[pick_idx];
            i2c_slv      <= slv_pad[{pick_idx, 3'b000} +: 8];
            i2c_addr     <= addr_pad[{pick_idx, 4'b0000} +: 16];
            i2c_wdata    <= wdata_pad[{pick_idx, 3'b000} +: 8];
          end
        end
        StExec: begin
          i2c_exec <= 1'b1;
          state    <= StWait;
`ifdef I2C_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        StWait: begin
          i2c_exec <= 1'b0;
          if (i2c_done) begin
            rsp_rdata <= i2c_rdata;
            rsp_err   <= i2c_ack;
            rsp_done  <= gnt;
            state     <= StResp;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_CYC - 20'd1) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
            rsp_done  <= gnt;
            state     <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
`endif
        end
        StResp: begin
          rsp_done <= '0;
          gnt      <= '0;
          rr_ptr   <= ptr_next;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arb.sv
// Randomized self-checking bench for i2c_arb against a transaction-level round-robin model.
// Timeout scenario is exercised only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_arb;

  localparam int unsigned N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_rw, req_bit16;
  logic [N*8-1:0]  req_slv, req_wdata;
  logic [N*16-1:0] req_addr;
  logic [N-1:0]    gnt, rsp_done;
  logic [7:0]      rsp_rdata;
  logic            rsp_err, busy, i2c_exec, i2c_bit_ctrl, i2c_rh_wl;
  logic [7:0]      i2c_slv, i2c_wdata, i2c_rdata;
  logic [15:0]     i2c_addr;
  logic            i2c_done, i2c_ack;

  always #5 clk = ~clk;

  i2c_arb #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(20'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_rw      (req_rw),
    .req_bit16   (req_bit16),
    .req_slv     (req_slv),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rsp_done    (rsp_done),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .i2c_exec    (i2c_exec),
    .i2c_bit_ctrl(i2c_bit_ctrl),
    .i2c_rh_wl   (i2c_rh_wl),
    .i2c_slv     (i2c_slv),
    .i2c_addr    (i2c_addr),
    .i2c_wdata   (i2c_wdata),
    .i2c_rdata   (i2c_rdata),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exec_cnt = 0;
  int done_cnt = 0;

  // Model state: round-robin pointer and the last reported response.
  int         ptr;
  logic [7:0] last_rdata;
  logic       last_err;

  always @(negedge clk) begin
    if (i2c_exec) exec_cnt++;
    if (|rsp_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({gnt, rsp_done, rsp_rdata, rsp_err, busy, i2c_exec, i2c_bit_ctrl, i2c_rh_wl,
                i2c_slv, i2c_addr, i2c_wdata});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    req_rw    = N'($urandom);
    req_bit16 = N'($urandom);
    req_slv   = (N*8)'($urandom);
    req_wdata = (N*8)'($urandom);
    req_addr  = (N*16)'($urandom);
  endtask

  // Called in an IDLE cycle with req already driven; ends in the following IDLE cycle.
  // dly < 0 means the master never answers (watchdog build only).
  task automatic run_txn(input int dly, input logic [7:0] rd, input logic ack,
                         input bit scramble);
    int          w, e0, d0;
    logic [33:0] exp_f;
    logic [7:0]  exp_rd;
    logic        exp_err;
    w     = pick(req, ptr);
    exp_f = {req_bit16[w], req_rw[w], req_slv[w*8+:8], req_addr[w*16+:16], req_wdata[w*8+:8]};
    e0    = exec_cnt;
    d0    = done_cnt;
    chk("idle_busy", 64'(busy), 64'd0);
    step();
    chk("gnt", 64'(gnt), 64'(1 << w));
    chk("exec_early", 64'(i2c_exec), 64'd0);
    if (scramble) begin
      req = N'($urandom);
      rand_fields();
      i2c_done  = 1'($urandom);
      i2c_rdata = 8'($urandom);
      i2c_ack   = 1'($urandom);
    end
    step();
    i2c_done = 1'b0;
    chk("exec", 64'(i2c_exec), 64'd1);
    chk("fields", 64'({i2c_bit_ctrl, i2c_rh_wl, i2c_slv, i2c_addr, i2c_wdata}), 64'(exp_f));
    chk("no_early_done", 64'(rsp_done), 64'd0);
`ifdef I2C_ARB_TIMEOUT_EN
    if (dly < 0) begin
      int n;
      n = 0;
      while (n < 200 && rsp_done == '0) begin
        step();
        n++;
      end
      chk("timeout_cyc", 64'(n), 64'd100);
      exp_rd  = 8'h00;
      exp_err = 1'b1;
    end else
`endif
    begin
      repeat (dly) step();
      chk("fields_hold", 64'({i2c_bit_ctrl, i2c_rh_wl, i2c_slv, i2c_addr, i2c_wdata}),
          64'(exp_f));
      i2c_done  = 1'b1;
      i2c_rdata = rd;
      i2c_ack   = ack;
      step();
      i2c_done  = 1'b0;
      i2c_rdata = 8'($urandom);
      i2c_ack   = 1'($urandom);
      exp_rd    = rd;
      exp_err   = ack;
    end
    chk("rsp_done", 64'(rsp_done), 64'(1 << w));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    step();
    chk("back_idle", 64'({gnt, rsp_done, busy}), 64'd0);
    chk("one_exec", 64'(exec_cnt - e0), 64'd1);
    chk("one_done", 64'(done_cnt - d0), 64'd1);
    last_rdata = exp_rd;
    last_err   = exp_err;
    ptr        = (w + 1) % N;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("reset_outs", all_outs(), 64'd0);
    step();
    rst        = 1'b0;
    ptr        = 0;
    last_rdata = 8'h00;
    last_err   = 1'b0;
  endtask

  task automatic stray_done();
    req       = '0;
    i2c_done  = 1'b1;
    i2c_rdata = 8'($urandom);
    i2c_ack   = 1'b1;
    step();
    i2c_done = 1'b0;
    step();
    chk("stray_idle", 64'({busy, rsp_done, gnt}), 64'd0);
    chk("stray_resp", 64'({rsp_rdata, rsp_err}), 64'({last_rdata, last_err}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1;
    req = '0;
    rand_fields();
    i2c_rdata = '0;
    i2c_done  = 1'b0;
    i2c_ack   = 1'b0;
    step();
    do_reset();

    // Contention from reset: both held, grants must alternate 0,1,0,1.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk("rr_model", 64'(pick(req, ptr)), 64'(k % 2));
      rand_fields();
      run_txn(k, 8'($urandom), 1'b0, 1'b0);
    end

    // Directed single write to requester 0.
    do_reset();
    req       = 2'b01;
    req_rw    = 2'b00;
    req_bit16 = 2'b00;
    req_slv   = {8'h00, 8'h98};
    req_addr  = {16'h0000, 16'h00FF};
    req_wdata = {8'h00, 8'h80};
    run_txn(3, 8'h00, 1'b0, 1'b0);

    // Directed read with NACK from requester 1.
    req     = 2'b10;
    req_rw  = 2'b10;
    req_slv = {8'h99, 8'h00};
    run_txn(2, 8'hA5, 1'b1, 1'b0);

    stray_done();

    // Abort mid-WAIT via reset.
    req = 2'b10;
    rand_fields();
    d0 = done_cnt;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_outs", all_outs(), 64'd0);
    req = '0;
    step();
    step();
    rst = 1'b0;
    ptr = 0;
    last_rdata = 8'h00;
    last_err   = 1'b0;
    step();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    req = 2'b11;
    rand_fields();
    run_txn(1, 8'($urandom), 1'b0, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    req = N'($urandom_range(1, 3));
    rand_fields();
    run_txn(-1, 8'h00, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) stray_done();
      req = N'($urandom_range(1, 3));
      rand_fields();
      run_txn(int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
